// File: rtl/step_seg_sequencer.sv
// Segment scheduler for acc_step_gen: queues (dt, steps) segments and
// issues gapless single-cycle load pulses, flagging starvation aborts.
module step_seg_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_stb,
   input  logic [31:0]              wr_dt,
   input  logic [31:0]              wr_steps,
   output logic                     wr_ready,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     clear_err,
   output logic [31:0]              gen_dt_val,
   output logic [31:0]              gen_steps_val,
   output logic                     gen_load,
   input  logic                     gen_done,
   input  logic                     gen_abort,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic [15:0]              seg_count,
   output logic                     err_underrun,
   output logic                     err_overflow,
   output logic                     err_bad_seg
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_DATA,
      ABORTED
   } state_t;

   state_t state, state_nx;

   logic [31:0]   dt_mem    [DEPTH];
   logic [31:0]   steps_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   logic empty, full, bad_fields;
   logic push_ok, load, underrun_ev;

   assign full       = (level == (AW+1)'(DEPTH));
   assign empty      = (level == '0);
   assign wr_ready   = !full;
   assign bad_fields = (wr_dt == '0) || (wr_steps == '0);
   assign push_ok    = wr_stb && !full && !bad_fields && !stop;
   assign busy       = (state == RUN) || (state == WAIT_DATA);

   // A done that coincides with our own load pulse belongs to the
   // previous segment's handoff and is ignored, so loads never abut.
   always_comb begin
      state_nx    = state;
      load        = 1'b0;
      underrun_ev = 1'b0;
      if (stop) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE, ABORTED: begin
               if (start && !empty) begin
                  load     = 1'b1;
                  state_nx = RUN;
               end
            end
            RUN: begin
               if (gen_done && !gen_load) begin
                  if (!empty) load = 1'b1;
                  else        state_nx = WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (!empty) begin
                  load     = 1'b1;
                  state_nx = RUN;
               end else if (gen_abort) begin
                  underrun_ev = 1'b1;
                  state_nx    = ABORTED;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         dt_mem[wr_ptr]    <= wr_dt;
         steps_mem[wr_ptr] <= wr_steps;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         gen_load      <= 1'b0;
         gen_dt_val    <= '0;
         gen_steps_val <= '0;
         seg_count     <= '0;
      end else if (stop) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         gen_load  <= 1'b0;
         seg_count <= '0;
      end else begin
         state    <= state_nx;
         gen_load <= load;
         level    <= level + (AW+1)'(push_ok) - (AW+1)'(load);
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr        <= rd_ptr + 1'b1;
            gen_dt_val    <= dt_mem[rd_ptr];
            gen_steps_val <= steps_mem[rd_ptr];
            seg_count     <= seg_count + 16'd1;
         end
      end
   end

   // Sticky flags: a new event in the same cycle beats clear_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_underrun <= 1'b0;
         err_overflow <= 1'b0;
         err_bad_seg  <= 1'b0;
      end else begin
         err_underrun <= (err_underrun && !clear_err) || underrun_ev;
         err_overflow <= (err_overflow && !clear_err) || (wr_stb && full);
         err_bad_seg  <= (err_bad_seg && !clear_err)
                         || (wr_stb && bad_fields);
      end
   end

endmodule

// File: tb/tb_step_seg_sequencer.sv
// Randomized bench for step_seg_sequencer against a queue-based
// reference model of the scheduling rules.
module tb_step_seg_sequencer;

   localparam int DEPTH = 4;
   localparam int NCYC  = 4000;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_WAIT  = 2;
   localparam int M_ABORT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_stb = 1'b0;
   logic [31:0] wr_dt = '0;
   logic [31:0] wr_steps = '0;
   logic        wr_ready;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear_err = 1'b0;
   logic [31:0] gen_dt_val;
   logic [31:0] gen_steps_val;
   logic        gen_load;
   logic        gen_done = 1'b0;
   logic        gen_abort = 1'b0;
   logic [2:0]  level;
   logic        busy;
   logic [15:0] seg_count;
   logic        err_underrun;
   logic        err_overflow;
   logic        err_bad_seg;

   int checks = 0;
   int errors = 0;

   step_seg_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .wr_stb(wr_stb),
      .wr_dt(wr_dt),
      .wr_steps(wr_steps),
      .wr_ready(wr_ready),
      .start(start),
      .stop(stop),
      .clear_err(clear_err),
      .gen_dt_val(gen_dt_val),
      .gen_steps_val(gen_steps_val),
      .gen_load(gen_load),
      .gen_done(gen_done),
      .gen_abort(gen_abort),
      .level(level),
      .busy(busy),
      .seg_count(seg_count),
      .err_underrun(err_underrun),
      .err_overflow(err_overflow),
      .err_bad_seg(err_bad_seg)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] q_dt[$];
   logic [31:0] q_st[$];
   int          m_mode;
   bit          m_load;
   logic [31:0] m_dt, m_st;
   logic [15:0] m_cnt;
   bit          m_under, m_over, m_bad;
   int          n_loads = 0;
   int          n_under = 0;
   int          n_over  = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("level", 32'(level), 32'(q_dt.size()));
      check("wr_ready", 32'(wr_ready), 32'(q_dt.size() < DEPTH));
      check("gen_load", 32'(gen_load), 32'(m_load));
      check("gen_dt_val", gen_dt_val, m_dt);
      check("gen_steps_val", gen_steps_val, m_st);
      check("seg_count", 32'(seg_count), 32'(m_cnt));
      check("busy", 32'(busy),
            32'(m_mode == M_RUN || m_mode == M_WAIT));
      check("err_underrun", 32'(err_underrun), 32'(m_under));
      check("err_overflow", 32'(err_overflow), 32'(m_over));
      check("err_bad_seg", 32'(err_bad_seg), 32'(m_bad));
   endtask

   task automatic model_step();
      bit have, do_load, ev_under, ev_over, ev_bad, accept;
      if (reset) begin
         q_dt.delete();
         q_st.delete();
         m_mode  = M_IDLE;
         m_load  = 0;
         m_dt    = '0;
         m_st    = '0;
         m_cnt   = '0;
         m_under = 0;
         m_over  = 0;
         m_bad   = 0;
         return;
      end
      have     = q_dt.size() > 0;
      ev_over  = wr_stb && q_dt.size() == DEPTH;
      ev_bad   = wr_stb && (wr_dt == 0 || wr_steps == 0);
      ev_under = !stop && m_mode == M_WAIT && !have && gen_abort;
      accept   = wr_stb && !ev_over && !ev_bad;
      if (clear_err) begin
         m_under = 0;
         m_over  = 0;
         m_bad   = 0;
      end
      if (ev_under) m_under = 1;
      if (ev_over)  m_over  = 1;
      if (ev_bad)   m_bad   = 1;
      if (ev_under) n_under++;
      if (ev_over)  n_over++;
      if (stop) begin
         q_dt.delete();
         q_st.delete();
         m_load = 0;
         m_cnt  = '0;
         m_mode = M_IDLE;
         return;
      end
      do_load = 0;
      case (m_mode)
         M_IDLE, M_ABORT: do_load = start && have;
         M_RUN: begin
            if (gen_done) begin
               if (have) do_load = 1;
               else      m_mode = M_WAIT;
            end
         end
         M_WAIT: begin
            if (have)           do_load = 1;
            else if (gen_abort) m_mode = M_ABORT;
         end
         default: ;
      endcase
      if (do_load) begin
         m_mode = M_RUN;
         m_dt   = q_dt.pop_front();
         m_st   = q_st.pop_front();
         m_cnt  = m_cnt + 16'd1;
         n_loads++;
      end
      m_load = do_load;
      if (accept) begin
         q_dt.push_back(wr_dt);
         q_st.push_back(wr_steps);
      end
   endtask

   function automatic logic [31:0] rand_field();
      if ($urandom_range(0, 11) == 0) return 32'd0;
      return 32'($urandom_range(1, 1000));
   endfunction

   initial begin
      int push_pct;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (cyc > 0) compare_all();
         push_pct  = 10 + 20 * ((cyc / 400) % 5);
         reset     = (cyc < 3) || ($urandom_range(0, 799) == 0);
         stop      = $urandom_range(0, 99) == 0;
         clear_err = $urandom_range(0, 39) == 0;
         start     = $urandom_range(0, 9) < 7;
         wr_stb    = $urandom_range(0, 99) < push_pct;
         wr_dt     = rand_field();
         wr_steps  = rand_field();
         gen_done  = !m_load && ($urandom_range(0, 3) == 0);
         gen_abort = $urandom_range(0, 5) == 0;
         model_step();
      end
      @(negedge clk);
      compare_all();
      check("loads_seen", 32'(n_loads > 20), 32'd1);
      check("underruns_seen", 32'(n_under > 0), 32'd1);
      check("overflows_seen", 32'(n_over > 0), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
